// File: rtl/load_store_unit_if.sv
// load_store_unit_if: processor request/response and DataMemoy bus of the load/store unit
interface load_store_unit_if;
  logic        req, we, sign_ext;
  logic [1:0]  size;
  logic [15:0] baddr;
  logic [63:0] wdata, rdata, datawr, datard;
  logic        busy, done, err, memWr, memRd;
  logic [12:0] Addres;
  modport slave (input req, we, size, sign_ext, baddr, wdata, datard,
                 output busy, done, err, rdata, Addres, memWr, memRd, datawr);
  modport master (output req, we, size, sign_ext, baddr, wdata, datard,
                  input busy, done, err, rdata, Addres, memWr, memRd, datawr);
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: 1/2/4/8-byte loads/stores onto 64-bit DataMemoy words with RMW partial stores.
// Define LSU_ERR_CNT_EN to add the saturating misaligned-request counter err_cnt.
module load_store_unit #(
  parameter int          RD_LATENCY = 1,
  parameter logic [12:0] IO_WADDR   = 13'h0100
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
`ifdef LSU_ERR_CNT_EN
  , output logic [7:0]      err_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t      state;
  logic        l_we, l_sx;
  logic [1:0]  l_size, cnt;
  logic [2:0]  l_off;
  logic [63:0] l_wdata;
  logic        mis, io, full;
  function automatic logic [63:0] extract(input logic [63:0] w, input logic [2:0] off,
                                          input logic [1:0] sz, input logic sx);
    logic [63:0] f;
    f = w >> {off, 3'b000};
    return sz == 2'b00 ? {{56{sx & f[7]}}, f[7:0]} :
           sz == 2'b01 ? {{48{sx & f[15]}}, f[15:0]} :
           sz == 2'b10 ? {{32{sx & f[31]}}, f[31:0]} : f;
  endfunction
  function automatic logic [63:0] merge(input logic [63:0] base, input logic [63:0] wd,
                                        input logic [2:0] off, input logic [1:0] sz);
    logic [7:0]  bm;
    logic [63:0] m;
    bm = (sz == 2'b00 ? 8'h01 : sz == 2'b01 ? 8'h03 : sz == 2'b10 ? 8'h0F : 8'hFF) << off;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{bm[i]}};
    return ((wd << {off, 3'b000}) & m) | (base & ~m);
  endfunction
  assign mis  = (bus.size == 2'b01 && bus.baddr[0]) ||
                (bus.size == 2'b10 && bus.baddr[1:0] != 2'b00) ||
                (bus.size == 2'b11 && bus.baddr[2:0] != 3'b000);
  assign io   = bus.baddr[15:3] == IO_WADDR;
  assign full = bus.size == 2'b11;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      l_we       <= 1'b0;
      l_sx       <= 1'b0;
      l_size     <= 2'b00;
      l_off      <= 3'b000;
      l_wdata    <= '0;
      cnt        <= 2'b00;
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
      bus.memRd  <= 1'b0;
      bus.memWr  <= 1'b0;
      bus.Addres <= '0;
      bus.datawr <= '0;
      bus.rdata  <= '0;
`ifdef LSU_ERR_CNT_EN
      err_cnt    <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: if (bus.req) begin
          l_we    <= bus.we;
          l_sx    <= bus.sign_ext;
          l_size  <= bus.size;
          l_off   <= bus.baddr[2:0];
          l_wdata <= bus.wdata;
          if (mis) begin
            state    <= DONE;
            bus.done <= 1'b1;
            bus.err  <= 1'b1;
`ifdef LSU_ERR_CNT_EN
            err_cnt  <= err_cnt + {7'd0, err_cnt != 8'hFF};
`endif
          end else if (!bus.we || !(full || io)) begin
            state      <= RD;
            cnt        <= 2'b00;
            bus.memRd  <= 1'b1;
            bus.Addres <= bus.baddr[15:3];
          end else begin
            // full and IO stores need no read; IO unmasked lanes are zero
            state      <= WR;
            bus.memWr  <= 1'b1;
            bus.Addres <= bus.baddr[15:3];
            bus.datawr <= merge(64'd0, bus.wdata, bus.baddr[2:0], bus.size);
          end
        end
        RD: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'(RD_LATENCY - 1)) begin
            bus.memRd <= 1'b0;
            if (l_we) begin
              state      <= WR;
              bus.memWr  <= 1'b1;
              bus.datawr <= merge(bus.datard, l_wdata, l_off, l_size);
            end else begin
              state     <= DONE;
              bus.done  <= 1'b1;
              bus.rdata <= extract(bus.datard, l_off, l_size, l_sx);
            end
          end
        end
        WR: begin
          state     <= DONE;
          bus.memWr <= 1'b0;
          bus.done  <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.err  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the processor datapath and DataMemoy and is the only master driving DataMemoy's Addres/memWr/memRd/datawr.
- Converts processor byte-addressed loads and stores of 1/2/4/8 bytes into 64-bit word accesses.
- Loads are extracted from the returned word and sign- or zero-extended.
- Partial stores use a read-modify-write sequence. Misaligned accesses are rejected.

Parameters:
- RD_LATENCY, 1: cycles from memRd assertion to datard valid; legal range 1..3.
- IO_WADDR, 13'h0100: word address of the switch/LED mapped word in DataMemoy.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  access request; sampled only in IDLE
- we  in  1  1=store, 0=load
- size  in  2  00=byte, 01=half, 10=word, 11=dword
- sign_ext  in  1  loads only: 1=sign-extend, 0=zero-extend
- baddr  in  16  byte address; word = baddr[15:3], offset = baddr[2:0]
- wdata  in  64  store data, right-aligned
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at the end of every accepted request
- err  out  1  valid with done; 1 = misaligned, no memory access made
- rdata  out  64  extended load result; updates only on a successful load done
- Addres  out  13  to DataMemoy
- memWr  out  1  to DataMemoy
- memRd  out  1  to DataMemoy
- datawr  out  64  to DataMemoy
- datard  in  64  from DataMemoy

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy, done, err, memWr, memRd = 0.
  - Addres = 0, datawr = 0, rdata = 0; latched request registers cleared.
- FSM states: IDLE, RD, WR, DONE.
- IDLE: when req=1, latch we/size/sign_ext/baddr/wdata. Misalignment is checked in this order:
  - Misaligned when (size=01 and baddr[0]!=0), (size=10 and baddr[1:0]!=0), or (size=11 and baddr[2:0]!=0).
  - If misaligned -> DONE with err=1. memRd and memWr never assert.
  - Load -> RD.
  - Store, full (size=11) or word == IO_WADDR -> WR.
  - Store, partial -> RD.
- RD: memRd=1, Addres=word. Stays in RD for RD_LATENCY cycles; datard is captured into a 64-bit buffer on the last RD clock edge.
  - Load -> DONE.
  - Store -> WR.
- WR: memWr=1 for exactly one cycle; Addres = word; datawr = merged word. -> DONE.
- Merge rule:
  - Lanes are selected by a byte mask: 1/2/4/8 bytes starting at offset*8 bits.
  - Masked lanes take wdata shifted left by offset*8 bits; unmasked lanes keep the captured word.
  - IO word: unmasked lanes are 0; no read is performed.
- Load extract:
  - field = buffer >> (offset*8), truncated to 8/16/32/64 bits.
  - sign_ext=1: replicate the field MSB up to bit 63; else zero-fill.
  - size=11 ignores sign_ext.
- DONE: done=1 and err valid for one cycle; rdata is updated on the same edge that enters DONE. -> IDLE.
- Whenever memRd=0 and memWr=0, Addres and datawr hold their last values. memRd and memWr are never both 1.
- req in any state other than IDLE is ignored; the processor must wait for done.
- Latency, RD_LATENCY=1, counted from the accepting edge to the done cycle:
  - load: 2 cycles
  - full/IO store: 2 cycles
  - partial store: 3 cycles
  - misaligned: 1 cycle
- Reset mid-operation: state returns to IDLE immediately. A WR cycle cut by reset may or may not have written; the memory contents are then undefined for that word only.

Optional Feature:
- Macro: LSU_ERR_CNT_EN.
- When defined:
  - Extra output err_cnt [7:0] counts misaligned requests.
  - It saturates at 8'hFF and is reset to 0 by rst_n.
  - It increments on the edge entering DONE with err=1.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Partial store: store byte 8'hA5 to baddr 16'h0003 over a memory word 0 of 64'h1111_2222_3333_4444 -> RD at word 0, then WR with datawr=64'h1111_2222_A533_4444; done 3 cycles after accept, err=0.
- Signed byte load: load byte baddr 16'h0003, sign_ext=1 -> rdata=64'hFFFF_FFFF_FFFF_FFA5. Same load with sign_ext=0 -> 64'h0000_0000_0000_00A5.
- Full store: store dword 64'h8 to baddr 16'h0000 -> no memRd; memWr for one cycle with Addres=0, datawr=8; done 2 cycles after accept.
- IO word: half store 16'h0007 to baddr 16'h0800 (word 13'h0100) -> no read; datawr=64'h7. Then dword load of that word with sw=9 -> rdata=64'h9.
- Misaligned: word store at baddr 16'h0006 -> done with err=1 one cycle after accept; memWr and memRd stay 0. With LSU_ERR_CNT_EN, err_cnt goes 0->1.
- Reset mid-operation: pull rst_n low during RD of a load -> busy=0, memRd=0, rdata=0 asynchronously. The next req after release completes normally.
